producto_a_bcd: RTL and testbench

//   Sequential binary-to-BCD converter directly downstream of the n-bit array

---
 rtl/producto_a_bcd.sv | 116 +++++++++++
 tb/tb_producto_a_bcd.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/producto_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Sits between the array multiplier and the 7-segment display stage.
module producto_a_bcd #(
  parameter int N = 4,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   product,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*D-1:0]   bcd,
  output logic             ovf,
  output logic             busy
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);

  localparam longint DMAX = longint'(10) ** D;
  localparam longint PMAX = (longint'(1) << W) - 1;

  if (DMAX <= PMAX) begin : g_chk
    $fatal(1, "producto_a_bcd: D too small for product width");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_sh;
  logic [4*D-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic [4*D-1:0]   r_bcd;
  logic             r_ovf;
  logic [4*D-1:0]   w_adj;
  logic [4*D-1:0]   w_acc_sh;
  logic             w_last;

  assign w_last = (r_cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Add-3 on every digit >=5, then shift in the next product bit.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < D; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_acc_sh = {w_adj[4*D-2:0], r_sh[W-1]};
  end

  // Conversion datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_cy  <= 1'b0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh  <= product;
            r_cy  <= carry_in;
            r_acc <= '0;
            r_cnt <= CW'(W);
          end
        end
        SHIFT: begin
          r_acc <= w_acc_sh;
          r_sh  <= {r_sh[W-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_bcd <= w_acc_sh;
            r_ovf <= r_cy;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign bcd       = r_bcd;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_producto_a_bcd.sv
// Bench for producto_a_bcd: vector table, corner sequences,
// exhaustive sweep with random stalls, scoreboard queue.
module tb_producto_a_bcd;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  product = 8'd0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] bcd;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        rand_mode = 1'b0;
  logic        or_man = 1'b1;

  logic [12:0] q[$];
  logic [11:0] last_bcd = 12'h0;
  logic        last_ovf = 1'b0;
  logic        prev_ov = 1'b0;
  logic        pend = 1'b0;
  logic        have_acc = 1'b0;
  int          acc_cyc = 0;

  typedef struct {
    logic [7:0]  p;
    logic        c;
    logic [11:0] eb;
    logic        eo;
  } vec_t;

  vec_t vt[10];

  producto_a_bcd #(.N(4), .D(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : or_man;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100 % 10);
    t = 4'(v / 10 % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Monitor: latency, spacing, scoreboard pop, hold checks.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_bcd = 12'h0;
      last_ovf = 1'b0;
      prev_ov  = 1'b0;
      pend     = 1'b0;
      have_acc = 1'b0;
    end else begin
      if (out_valid && !prev_ov && pend) begin
        chk("latency", cyc - acc_cyc, W);
        pend = 1'b0;
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        if (have_acc)
          chk("accept_spacing", int'((cyc + 1 - acc_cyc) >= W + 2), 1);
        acc_cyc  = cyc + 1;
        pend     = 1'b1;
        have_acc = 1'b1;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("bcd", int'(bcd), int'(q[0][11:0]));
          chk("ovf", int'(ovf), int'(q[0][12]));
          chk("in_ready_done", int'(in_ready), 0);
          chk("busy_done", int'(busy), 1);
          if (out_ready) begin
            last_bcd = q[0][11:0];
            last_ovf = q[0][12];
            void'(q.pop_front());
          end
        end
      end else begin
        chk("bcd_hold", int'(bcd), int'(last_bcd));
        chk("ovf_hold", int'(ovf), int'(last_ovf));
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic c,
                      input logic [11:0] eb, input logic eo);
    int n;
    @(posedge clk);
    #2;
    product  = p;
    carry_in = c;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q.push_back({eo, eb});
    #2;
    in_valid = 1'b0;
    product  = ~p;
    carry_in = ~c;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    logic c;

    vt[0] = '{8'd0,   1'b0, 12'h000, 1'b0};
    vt[1] = '{8'hE1,  1'b1, 12'h225, 1'b1};
    vt[2] = '{8'd12,  1'b0, 12'h012, 1'b0};
    vt[3] = '{8'd200, 1'b1, 12'h200, 1'b1};
    vt[4] = '{8'd128, 1'b0, 12'h128, 1'b0};
    vt[5] = '{8'd255, 1'b1, 12'h255, 1'b1};
    vt[6] = '{8'd9,   1'b0, 12'h009, 1'b0};
    vt[7] = '{8'd10,  1'b1, 12'h010, 1'b1};
    vt[8] = '{8'd100, 1'b0, 12'h100, 1'b0};
    vt[9] = '{8'd199, 1'b1, 12'h199, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_ovf", int'(ovf), 0);
    #1;
    rst = 1'b0;

    or_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vt[i].p, vt[i].c, vt[i].eb, vt[i].eo);
      @(negedge clk);
      chk("busy_shift", int'(busy), 1);
      chk("in_ready_shift", int'(in_ready), 0);
    end
    drain();

    // Hold in DONE with out_ready low for 5 cycles.
    @(posedge clk);
    #2;
    or_man = 1'b0;
    send(8'd99, 1'b0, 12'h099, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", int'(out_valid), 1);
    repeat (5) @(negedge clk);
    chk("stall_still_valid", int'(out_valid), 1);
    #7;
    or_man = 1'b1;
    drain();

    // Back-to-back with in_valid held high.
    @(posedge clk);
    #2;
    product  = 8'd12;
    carry_in = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_accept", int'(in_ready), 1);
      @(posedge clk);
      if (k == 0) q.push_back({1'b0, 12'h012});
      else        q.push_back({1'b1, 12'h200});
      #2;
      product  = 8'd200;
      carry_in = 1'b1;
    end
    in_valid = 1'b0;
    drain();

    // Reset during the 3rd SHIFT cycle aborts the conversion.
    send(8'd77, 1'b0, 12'h077, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_bcd", int'(bcd), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_result", int'(out_valid), 0);
    send(8'd128, 1'b0, 12'h128, 1'b0);
    drain();

    // Exhaustive sweep with random downstream stalls.
    rand_mode = 1'b1;
    for (int v = 0; v < 256; v++) begin
      c = 1'($urandom_range(0, 1));
      send(8'(v), c, to_bcd(v), c);
    end
    drain();
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_idle", int'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
